fmul_pipe_sched: RTL and testbench

- Issue scheduler and pipeline controller for the shared 3-stage FP multiplier (s1 prod/special-case, s2 normalize-shift, s3 round).
- Round-robin arbitrates two issue requesters onto the single multiplier datapath.
- Owns per-stage valid bits, robIdx/rm sideband and backpressure; drives the stage-enable strobes the datapath registers use.
- Applies redirect flushes to in-flight operations.

---
 rtl/fmul_pipe_sched_if.sv | 46 ++++
 rtl/fmul_pipe_sched.sv | 113 +++++++++++
 tb/tb_fmul_pipe_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_pipe_sched_if.sv
// Issue/writeback/redirect signal bundle for the shared FP multiplier scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface fmul_pipe_sched_if #(
  parameter int unsigned IDX_W = 6
);
  logic             io_in0_valid;
  logic             io_in0_ready;
  logic             io_in0_bits_robIdx_flag;
  logic [IDX_W-1:0] io_in0_bits_robIdx_value;
  logic [2:0]       io_in0_bits_rm;
  logic             io_in1_valid;
  logic             io_in1_ready;
  logic             io_in1_bits_robIdx_flag;
  logic [IDX_W-1:0] io_in1_bits_robIdx_value;
  logic [2:0]       io_in1_bits_rm;
  logic             io_redirect_valid;
  logic             io_redirect_bits_robIdx_flag;
  logic [IDX_W-1:0] io_redirect_bits_robIdx_value;
  logic             io_redirect_bits_level;
  logic             io_s0_sel;
  logic [2:0]       io_stage_en;
  logic             io_out_valid;
  logic             io_out_ready;
  logic             io_out_bits_robIdx_flag;
  logic [IDX_W-1:0] io_out_bits_robIdx_value;
  logic [2:0]       io_out_bits_rm;
  logic [1:0]       io_busy_cnt;

  modport slave (
    input  io_in0_valid, io_in0_bits_robIdx_flag, io_in0_bits_robIdx_value, io_in0_bits_rm,
    input  io_in1_valid, io_in1_bits_robIdx_flag, io_in1_bits_robIdx_value, io_in1_bits_rm,
    input  io_redirect_valid, io_redirect_bits_robIdx_flag, io_redirect_bits_robIdx_value,
    input  io_redirect_bits_level, io_out_ready,
    output io_in0_ready, io_in1_ready, io_s0_sel, io_stage_en, io_out_valid,
    output io_out_bits_robIdx_flag, io_out_bits_robIdx_value, io_out_bits_rm, io_busy_cnt
  );

  modport master (
    output io_in0_valid, io_in0_bits_robIdx_flag, io_in0_bits_robIdx_value, io_in0_bits_rm,
    output io_in1_valid, io_in1_bits_robIdx_flag, io_in1_bits_robIdx_value, io_in1_bits_rm,
    output io_redirect_valid, io_redirect_bits_robIdx_flag, io_redirect_bits_robIdx_value,
    output io_redirect_bits_level, io_out_ready,
    input  io_in0_ready, io_in1_ready, io_s0_sel, io_stage_en, io_out_valid,
    input  io_out_bits_robIdx_flag, io_out_bits_robIdx_value, io_out_bits_rm, io_busy_cnt
  );
endinterface

// File: rtl/fmul_pipe_sched.sv
// Round-robin issue scheduler and 3-stage valid/sideband pipeline controller for the
// shared FP multiplier, including redirect flush of in-flight and incoming ops.
module fmul_pipe_sched #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned LAT   = 3
) (
  input  logic               clock,
  input  logic               reset,
  fmul_pipe_sched_if.slave   bus
);
  typedef struct packed {
    logic             flag;
    logic [IDX_W-1:0] value;
  } rob_t;

  function automatic logic is_after(input rob_t a, input rob_t b);
    return (a.flag ^ b.flag) ^ (a.value > b.value);
  endfunction

  function automatic logic need_flush(input logic rv, input logic lvl, input rob_t x, input rob_t r);
    return rv & (is_after(x, r) | (lvl & (x == r)));
  endfunction

  logic       v1, v2, v3;
  logic       ptr, sel_q;
  rob_t       rob1, rob2, rob3;
  logic [2:0] rm1, rm2, rm3;

  rob_t       rob_in0, rob_in1, rob_redir, rob_in;
  logic [2:0] rm_in;
  logic       grant, gidx;
  logic       s1_rdy, s2_rdy, s3_rdy;
  logic       nf_in, nf1, nf2, nf3;
  logic [2:0] stage_en;

  always_comb begin
    rob_in0   = '{flag: bus.io_in0_bits_robIdx_flag, value: bus.io_in0_bits_robIdx_value};
    rob_in1   = '{flag: bus.io_in1_bits_robIdx_flag, value: bus.io_in1_bits_robIdx_value};
    rob_redir = '{flag: bus.io_redirect_bits_robIdx_flag, value: bus.io_redirect_bits_robIdx_value};

    // Both valid: pointer decides; otherwise the lone valid requester wins.
    grant  = (bus.io_in0_valid | bus.io_in1_valid) & ~reset;
    gidx   = (bus.io_in0_valid & bus.io_in1_valid) ? ptr : bus.io_in1_valid;
    rob_in = gidx ? rob_in1 : rob_in0;
    rm_in  = gidx ? bus.io_in1_bits_rm : bus.io_in0_bits_rm;

    s3_rdy = ~v3 | bus.io_out_ready;
    s2_rdy = ~v2 | s3_rdy;
    s1_rdy = ~v1 | s2_rdy;

    nf_in = need_flush(bus.io_redirect_valid, bus.io_redirect_bits_level, rob_in, rob_redir);
    nf1   = need_flush(bus.io_redirect_valid, bus.io_redirect_bits_level, rob1,   rob_redir);
    nf2   = need_flush(bus.io_redirect_valid, bus.io_redirect_bits_level, rob2,   rob_redir);
    nf3   = need_flush(bus.io_redirect_valid, bus.io_redirect_bits_level, rob3,   rob_redir);

    stage_en = '0;
    if (!reset) begin
      stage_en[2] = v2 & s3_rdy;
      stage_en[1] = v1 & s2_rdy;
      stage_en[0] = grant & s1_rdy;
    end
  end

  assign bus.io_stage_en              = stage_en;
  assign bus.io_in0_ready             = s1_rdy & grant & ~gidx;
  assign bus.io_in1_ready             = s1_rdy & grant & gidx;
  assign bus.io_s0_sel                = grant ? gidx : sel_q;
  assign bus.io_out_valid             = v3 & ~nf3;
  assign bus.io_out_bits_robIdx_flag  = rob3.flag;
  assign bus.io_out_bits_robIdx_value = rob3.value;
  assign bus.io_out_bits_rm           = rm3;
  assign bus.io_busy_cnt              = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

  // A stage either advances (taking upstream's valid, killed if flushed) or holds
  // its own valid, which a flush clears even while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      ptr   <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      v3 <= s3_rdy ? (v2 & ~nf2) : (v3 & ~nf3);
      v2 <= s2_rdy ? (v1 & ~nf1) : (v2 & ~nf2);
      v1 <= s1_rdy ? (grant & ~nf_in) : (v1 & ~nf1);
      if (grant & s1_rdy) ptr <= ~gidx;
      if (grant) sel_q <= gidx;
    end
  end

  always_ff @(posedge clock) begin
    if (stage_en[0]) begin
      rob1 <= rob_in;
      rm1  <= rm_in;
    end
    if (stage_en[1]) begin
      rob2 <= rob1;
      rm2  <= rm1;
    end
    if (stage_en[2]) begin
      rob3 <= rob2;
      rm3  <= rm2;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (int'(bus.io_busy_cnt) <= int'(LAT));
      assert (!(bus.io_in0_ready && bus.io_in1_ready));
    end
  end
endmodule

// File: tb/tb_fmul_pipe_sched.sv
// Directed bench for fmul_pipe_sched: latency, round-robin order, stall, flush
// (level 0/1, flag wrap, incoming op) and mid-flight reset.
module tb_fmul_pipe_sched;
  localparam int unsigned IDX_W = 6;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fmul_pipe_sched_if #(.IDX_W(IDX_W)) bus ();

  fmul_pipe_sched #(.IDX_W(IDX_W), .LAT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv0(input logic v, input logic f, input logic [IDX_W-1:0] val, input logic [2:0] rm);
    bus.io_in0_valid = v;
    bus.io_in0_bits_robIdx_flag = f;
    bus.io_in0_bits_robIdx_value = val;
    bus.io_in0_bits_rm = rm;
  endtask

  task automatic drv1(input logic v, input logic f, input logic [IDX_W-1:0] val, input logic [2:0] rm);
    bus.io_in1_valid = v;
    bus.io_in1_bits_robIdx_flag = f;
    bus.io_in1_bits_robIdx_value = val;
    bus.io_in1_bits_rm = rm;
  endtask

  task automatic redir(input logic v, input logic f, input logic [IDX_W-1:0] val, input logic lvl);
    bus.io_redirect_valid = v;
    bus.io_redirect_bits_robIdx_flag = f;
    bus.io_redirect_bits_robIdx_value = val;
    bus.io_redirect_bits_level = lvl;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, 3'd0);
    drv1(1'b0, 1'b0, '0, 3'd0);
    redir(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issues ops (0,a),(0,a+1),(0,a+2) from in0 with writeback blocked; returns at the
  // start of the cycle in which s3/s2/s1 hold a/a+1/a+2.
  task automatic fill3(input int a);
    do_reset();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b0, IDX_W'(a + i), 3'd0);
      tick();
    end
    idle();
  endtask

  int exp_v[4]  = '{10, 21, 12, 23};
  int exp_rm[4] = '{1, 2, 1, 2};

  initial begin
    // Reset behaviour and single-op latency
    reset = 1'b1;
    idle();
    bus.io_out_ready = 1'b1;
    drv0(1'b1, 1'b0, 6'd5, 3'd3);
    tick();
    chk("rst_in0_ready", bus.io_in0_ready, 0);
    chk("rst_stage_en", bus.io_stage_en, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.io_busy_cnt, 0);
    chk("rst_out_valid", bus.io_out_valid, 0);
    chk("t0_in0_ready", bus.io_in0_ready, 1);
    chk("t0_stage_en", bus.io_stage_en, 3'b001);
    chk("t0_sel", bus.io_s0_sel, 0);
    tick();
    drv0(1'b0, 1'b0, '0, 3'd0);
    #1;
    chk("t1_busy", bus.io_busy_cnt, 1);
    chk("t1_out_valid", bus.io_out_valid, 0);
    tick();
    chk("t2_busy", bus.io_busy_cnt, 1);
    tick();
    chk("t3_out_valid", bus.io_out_valid, 1);
    chk("t3_out_value", bus.io_out_bits_robIdx_value, 5);
    chk("t3_out_flag", bus.io_out_bits_robIdx_flag, 0);
    chk("t3_out_rm", bus.io_out_bits_rm, 3);
    chk("t3_busy", bus.io_busy_cnt, 1);
    tick();
    chk("t4_busy", bus.io_busy_cnt, 0);
    chk("t4_out_valid", bus.io_out_valid, 0);

    // Round-robin with both requesters valid
    do_reset();
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drv0(1'b1, 1'b0, IDX_W'(10 + i), 3'd1);
        drv1(1'b1, 1'b0, IDX_W'(20 + i), 3'd2);
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        chk("rr_sel", bus.io_s0_sel, i % 2);
        chk("rr_in0_ready", bus.io_in0_ready, (i % 2) == 0);
        chk("rr_in1_ready", bus.io_in1_ready, (i % 2) == 1);
      end
      if (i >= 3) begin
        chk("rr_out_valid", bus.io_out_valid, 1);
        chk("rr_out_value", bus.io_out_bits_robIdx_value, exp_v[i-3]);
        chk("rr_out_rm", bus.io_out_bits_rm, exp_rm[i-3]);
      end
      tick();
    end
    chk("rr_drain", bus.io_out_valid, 0);

    // Full pipe stalled for 5 cycles, then released
    do_reset();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b0, IDX_W'(30 + i), 3'd0);
      #1;
      chk("fill_in0_ready", bus.io_in0_ready, 1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drv0(1'b1, 1'b0, 6'd33, 3'd0);
      #1;
      chk("stall_in0_ready", bus.io_in0_ready, 0);
      chk("stall_stage_en", bus.io_stage_en, 0);
      chk("stall_out_valid", bus.io_out_valid, 1);
      chk("stall_out_value", bus.io_out_bits_robIdx_value, 30);
      chk("stall_busy", bus.io_busy_cnt, 3);
      tick();
    end
    idle();
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rel_out_valid", bus.io_out_valid, 1);
      chk("rel_out_value", bus.io_out_bits_robIdx_value, 30 + i);
      tick();
    end
    chk("rel_drain", bus.io_out_valid, 0);

    // Redirect (0,3) level 0 kills only s1 (0,4)
    fill3(2);
    redir(1'b1, 1'b0, 6'd3, 1'b0);
    #1;
    chk("l0_busy_pre", bus.io_busy_cnt, 3);
    chk("l0_out_valid", bus.io_out_valid, 1);
    tick();
    redir(1'b0, 1'b0, '0, 1'b0);
    bus.io_out_ready = 1'b1;
    #1;
    chk("l0_busy_post", bus.io_busy_cnt, 2);
    chk("l0_out0", bus.io_out_bits_robIdx_value, 2);
    tick();
    chk("l0_out1_valid", bus.io_out_valid, 1);
    chk("l0_out1", bus.io_out_bits_robIdx_value, 3);
    tick();
    chk("l0_drain", bus.io_out_valid, 0);

    // Redirect (0,3) level 1 kills s2 and s1; s3 (0,2) still fires
    fill3(2);
    bus.io_out_ready = 1'b1;
    redir(1'b1, 1'b0, 6'd3, 1'b1);
    #1;
    chk("l1_out_valid", bus.io_out_valid, 1);
    chk("l1_out_value", bus.io_out_bits_robIdx_value, 2);
    tick();
    redir(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("l1_busy_post", bus.io_busy_cnt, 0);
    chk("l1_out_valid_post", bus.io_out_valid, 0);

    // Flag wrap: s1 (1,1) is younger than redirect (0,60)
    do_reset();
    bus.io_out_ready = 1'b1;
    drv0(1'b1, 1'b1, 6'd1, 3'd0);
    #1;
    chk("wrap_in0_ready", bus.io_in0_ready, 1);
    tick();
    idle();
    redir(1'b1, 1'b0, 6'd60, 1'b0);
    #1;
    chk("wrap_busy_pre", bus.io_busy_cnt, 1);
    tick();
    redir(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("wrap_busy_post", bus.io_busy_cnt, 0);
    tick();
    chk("wrap_no_out", bus.io_out_valid, 0);

    // Incoming op (0,9) flushed by simultaneous redirect (0,8)
    do_reset();
    bus.io_out_ready = 1'b1;
    drv0(1'b1, 1'b0, 6'd9, 3'd0);
    redir(1'b1, 1'b0, 6'd8, 1'b0);
    #1;
    chk("inflush_ready", bus.io_in0_ready, 1);
    tick();
    idle();
    #1;
    chk("inflush_busy", bus.io_busy_cnt, 0);
    tick();
    tick();
    chk("inflush_no_out", bus.io_out_valid, 0);

    // Reset with 3 ops in flight; pointer returns to in0
    do_reset();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b0, IDX_W'(40 + i), 3'd0);
      drv1(1'b1, 1'b0, IDX_W'(50 + i), 3'd0);
      tick();
    end
    idle();
    #1;
    chk("mid_busy_pre", bus.io_busy_cnt, 3);
    reset = 1'b1;
    tick();
    chk("mid_busy_post", bus.io_busy_cnt, 0);
    chk("mid_out_valid", bus.io_out_valid, 0);
    reset = 1'b0;
    drv0(1'b1, 1'b0, 6'd1, 3'd0);
    drv1(1'b1, 1'b0, 6'd2, 3'd0);
    #1;
    chk("mid_sel", bus.io_s0_sel, 0);
    chk("mid_in0_ready", bus.io_in0_ready, 1);
    chk("mid_in1_ready", bus.io_in1_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
